// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel bus receive monitor: pixel, line and frame events
// Optional latch-while-lit detection is built when HUB75_RX_LATCH_GUARD_EN is defined.
module hub75_rx #(
  parameter int WIDTH       = 32,
  parameter int COL_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             R0,
  input  logic             G0,
  input  logic             B0,
  input  logic             R1,
  input  logic             G1,
  input  logic             B1,
  input  logic             clk_shft,
  input  logic             LAT,
  input  logic             OE,
  output logic             pix_valid,
  output logic [COL_W-1:0] pix_col,
  output logic [2:0]       pix_top,
  output logic [2:0]       pix_bot,
  output logic             line_valid,
  output logic [3:0]       line_row,
  output logic [COL_W:0]   line_cols,
  output logic             err_len,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic             err_latch
);

  localparam logic [COL_W:0]   FULL = (COL_W+1)'(WIDTH);
  localparam logic [COL_W:0]   ONE  = (COL_W+1)'(1);
  localparam logic [COL_W-1:0] LAST = COL_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [12:0] bus_in;
  logic [12:0] bus_s;
  logic [12:0] sync_q [SYNC_STAGES];

  logic [3:0]  row_s;
  logic [2:0]  top_s;
  logic [2:0]  bot_s;
  logic        shft_s, lat_s, oe_s;
  logic        shft_d, lat_d;
  logic        shft_rise, lat_rise;

  state_t      state, state_nxt;
  logic [COL_W:0] col_cnt, cnt_nxt, line_cnt;
  logic        ovf, ovf_nxt, line_ovf;

  assign bus_in = {D, C, B, A, R0, G0, B0, R1, G1, B1, clk_shft, LAT, OE};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Data and edges come from the same stage so they stay cycle-aligned.
  assign bus_s  = sync_q[SYNC_STAGES-1];
  assign row_s  = bus_s[12:9];
  assign top_s  = bus_s[8:6];
  assign bot_s  = bus_s[5:3];
  assign shft_s = bus_s[2];
  assign lat_s  = bus_s[1];
  assign oe_s   = bus_s[0];

  assign shft_rise = shft_s & ~shft_d;
  assign lat_rise  = lat_s & ~lat_d;

  // A shift coinciding with a latch is counted into the line before it clears.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = col_cnt;
    ovf_nxt   = ovf;
    if (shft_rise) begin
      state_nxt = SHIFT;
      if (col_cnt == FULL) ovf_nxt = 1'b1;
      else                 cnt_nxt = col_cnt + ONE;
    end
    line_cnt = cnt_nxt;
    line_ovf = ovf_nxt;
    if (lat_rise) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col_cnt     <= '0;
      ovf         <= 1'b0;
      shft_d      <= 1'b0;
      lat_d       <= 1'b0;
      pix_valid   <= 1'b0;
      pix_col     <= '0;
      pix_top     <= '0;
      pix_bot     <= '0;
      line_valid  <= 1'b0;
      line_row    <= '0;
      line_cols   <= '0;
      err_len     <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      col_cnt     <= cnt_nxt;
      ovf         <= ovf_nxt;
      shft_d      <= shft_s;
      lat_d       <= lat_s;
      pix_valid   <= shft_rise;
      line_valid  <= lat_rise;
      err_len     <= 1'b0;
      frame_start <= 1'b0;
      if (shft_rise) begin
        pix_col <= (col_cnt == FULL) ? LAST : col_cnt[COL_W-1:0];
        pix_top <= top_s;
        pix_bot <= bot_s;
      end
      if (lat_rise) begin
        line_row    <= row_s;
        line_cols   <= line_cnt;
        err_len     <= (line_cnt != FULL) || line_ovf;
        frame_start <= (row_s == 4'd0);
        if (row_s == 4'd0) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef HUB75_RX_LATCH_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst) err_latch <= 1'b0;
    else     err_latch <= lat_rise & ~oe_s;
  end
`else
  logic unused_oe;
  assign unused_oe = oe_s;
  assign err_latch = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - self-checking bench for hub75_rx with a queue-based event model
module tb_hub75_rx;

  localparam int WIDTH = 32;
  localparam int COL_W = 5;
`ifdef HUB75_RX_LATCH_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 0, B = 0, C = 0, D = 0;
  logic R0 = 0, G0 = 0, B0 = 0, R1 = 0, G1 = 0, B1 = 0;
  logic clk_shft = 0, LAT = 0, OE = 1;

  logic             pix_valid;
  logic [COL_W-1:0] pix_col;
  logic [2:0]       pix_top, pix_bot;
  logic             line_valid;
  logic [3:0]       line_row;
  logic [COL_W:0]   line_cols;
  logic             err_len, frame_start, err_latch;
  logic [7:0]       frame_cnt;

  hub75_rx #(.WIDTH(WIDTH), .COL_W(COL_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .clk_shft(clk_shft), .LAT(LAT), .OE(OE),
    .pix_valid(pix_valid), .pix_col(pix_col), .pix_top(pix_top), .pix_bot(pix_bot),
    .line_valid(line_valid), .line_row(line_row), .line_cols(line_cols),
    .err_len(err_len), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .err_latch(err_latch)
  );

  always #5 clk = ~clk;

  typedef struct { int col; logic [2:0] top; logic [2:0] bot; } pix_t;
  typedef struct { logic [3:0] row; int cols; logic err; logic fs; logic el; int fcnt; } line_t;
  typedef struct { int ncols; logic [3:0] row; logic oe; logic simul; int exp_cols; logic exp_err; } vec_t;

  pix_t  pq[$];
  line_t lq[$];
  pix_t  mp;
  line_t ml;
  vec_t  tbl[8];

  int checks = 0;
  int errors = 0;
  int line_n = 0;
  int frames = 0;
  bit got_line;
  int got_cols;
  logic got_err, got_el;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      if (pq.size() == 0) check("pix_unexpected", 1, 0);
      else begin
        mp = pq.pop_front();
        check("pix_col", int'(pix_col), mp.col);
        check("pix_top", int'(pix_top), int'(mp.top));
        check("pix_bot", int'(pix_bot), int'(mp.bot));
      end
    end
    if (line_valid) begin
      if (lq.size() == 0) check("line_unexpected", 1, 0);
      else begin
        ml = lq.pop_front();
        check("line_row", int'(line_row), int'(ml.row));
        check("line_cols", int'(line_cols), ml.cols);
        check("err_len", int'(err_len), int'(ml.err));
        check("frame_start", int'(frame_start), int'(ml.fs));
        check("frame_cnt", int'(frame_cnt), ml.fcnt);
        check("err_latch", int'(err_latch), int'(ml.el));
      end
      got_line = 1'b1;
      got_cols = int'(line_cols);
      got_err  = err_len;
      got_el   = err_latch;
    end
    check("stray_pulse", int'(!line_valid && (err_len || frame_start || err_latch)), 0);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pix(logic [2:0] t, logic [2:0] b);
    {R0, G0, B0} = t;
    {R1, G1, B1} = b;
  endtask

  task automatic push_pix(logic [2:0] t, logic [2:0] b);
    pix_t p;
    p.col = (line_n < WIDTH) ? line_n : WIDTH - 1;
    p.top = t;
    p.bot = b;
    pq.push_back(p);
    line_n++;
  endtask

  task automatic push_line(logic [3:0] row, logic oe);
    line_t l;
    l.row = row;
    l.cols = (line_n < WIDTH) ? line_n : WIDTH;
    l.err = (line_n != WIDTH);
    l.fs = (row == 4'd0);
    if (l.fs) frames++;
    l.fcnt = frames % 256;
    l.el = GUARD && !oe;
    lq.push_back(l);
    line_n = 0;
  endtask

  task automatic shift_col(logic [2:0] t, logic [2:0] b);
    set_pix(t, b);
    cyc(1);
    clk_shft = 1'b1;
    push_pix(t, b);
    cyc(4);
    clk_shft = 1'b0;
    cyc(3);
  endtask

  task automatic latch(logic [3:0] row, logic oe, logic simul, logic [2:0] t, logic [2:0] b);
    {D, C, B, A} = row;
    OE = oe;
    if (simul) set_pix(t, b);
    cyc(1);
    LAT = 1'b1;
    if (simul) begin
      clk_shft = 1'b1;
      push_pix(t, b);
    end
    push_line(row, oe);
    cyc(4);
    LAT = 1'b0;
    clk_shft = 1'b0;
    cyc(4);
  endtask

  task automatic send_line(int n, logic [3:0] row, logic oe, logic simul, bit rnd);
    logic [2:0] t;
    for (int i = 0; i < n; i++) begin
      t = rnd ? 3'($urandom) : ((i % 2 == 1) ? 3'b010 : 3'b101);
      shift_col(t, rnd ? 3'($urandom) : ~t);
    end
    t = rnd ? 3'($urandom) : 3'b110;
    latch(row, oe, simul, t, ~t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    check("rst_outputs_zero", int'(|{pix_valid, pix_col, pix_top, pix_bot, line_valid, line_row,
                                      line_cols, err_len, frame_start, frame_cnt, err_latch}), 0);
    cyc(1);
    rst = 1'b0;
    line_n = 0;
    frames = 0;
    cyc(2);
  endtask

  initial begin
    tbl[0] = '{32, 4'd5, 1'b1, 1'b0, 32, 1'b0};
    tbl[1] = '{31, 4'd5, 1'b1, 1'b0, 31, 1'b1};
    tbl[2] = '{34, 4'd3, 1'b1, 1'b0, 32, 1'b1};
    tbl[3] = '{31, 4'd7, 1'b1, 1'b1, 32, 1'b0};
    tbl[4] = '{0,  4'd9, 1'b1, 1'b0, 0,  1'b1};
    tbl[5] = '{32, 4'd2, 1'b0, 1'b0, 32, 1'b0};
    tbl[6] = '{32, 4'd4, 1'b1, 1'b1, 32, 1'b1};
    tbl[7] = '{1,  4'd8, 1'b0, 1'b0, 1,  1'b1};

    cyc(2);
    do_reset();

    // Edge-to-pulse latency of three clocks
    set_pix(3'b111, 3'b001);
    cyc(1);
    clk_shft = 1'b1;
    push_pix(3'b111, 3'b001);
    @(posedge clk); @(posedge clk); #1;
    check("latency_early", int'(pix_valid), 0);
    @(posedge clk); #1;
    check("latency_pix", int'(pix_valid), 1);
    cyc(1);
    clk_shft = 1'b0;
    cyc(3);
    latch(4'd14, 1'b1, 1'b0, 3'b000, 3'b000);

    for (int i = 0; i < 8; i++) begin
      got_line = 1'b0;
      send_line(tbl[i].ncols, tbl[i].row, tbl[i].oe, tbl[i].simul, 1'b0);
      check("tbl_line_seen", int'(got_line), 1);
      check("tbl_cols", got_cols, tbl[i].exp_cols);
      check("tbl_err_len", int'(got_err), int'(tbl[i].exp_err));
      check("tbl_err_latch", int'(got_el), int'(GUARD && !tbl[i].oe));
    end

    // Frame boundaries: rows 15, 0..15, 0
    do_reset();
    latch(4'd15, 1'b1, 1'b0, 3'b000, 3'b000);
    for (int r = 0; r < 16; r++) latch(4'(r), 1'b1, 1'b0, 3'b000, 3'b000);
    latch(4'd0, 1'b1, 1'b0, 3'b000, 3'b000);
    check("frame_cnt_two", int'(frame_cnt), 2);

    // Reset mid-line drops the partial line
    for (int i = 0; i < 10; i++) shift_col(3'b011, 3'b100);
    do_reset();
    got_line = 1'b0;
    send_line(32, 4'd6, 1'b1, 1'b0, 1'b0);
    check("post_rst_line_seen", int'(got_line), 1);
    check("post_rst_cols", got_cols, 32);
    check("post_rst_frame_cnt", int'(frame_cnt), 0);

    for (int k = 0; k < 16; k++) begin
      send_line(int'($urandom_range(28, 35)), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    cyc(4);
    check("pix_queue_drained", pq.size(), 0);
    check("line_queue_drained", lq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
# hub75_rx

Receive-side monitor for the HUB75 LED-matrix interface. It samples the panel bus (row address A–D, RGB pairs, shift clock, LAT, OE) with the system clock and reconstructs per-column pixel events, per-row line events and frame boundaries. It sits opposite the matrix driver, either as a loopback checker in the bench or as a panel emulator feeding a frame store. All inputs are asynchronous to `clk` and are synchronised internally.

## Interface

Parameters:
- `WIDTH`, 32, columns per shifted line; legal range 2–256.
- `COL_W`, 5, column index width; must equal clog2(`WIDTH`).
- `SYNC_STAGES`, 2, synchroniser depth on every bus input; legal range 2–3.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `A`, `B`, `C`, `D`  in  1 each  row address; `D` is MSB.
- `R0`, `G0`, `B0`  in  1 each  top-half pixel data.
- `R1`, `G1`, `B1`  in  1 each  bottom-half pixel data.
- `clk_shft`  in  1  panel shift clock; data is captured on its rising edge.
- `LAT`  in  1  line latch; a rising edge commits the line.
- `OE`  in  1  output enable, active-low: 0 means display on.
- `pix_valid`  out  1  one-cycle pulse per captured column.
- `pix_col`  out  `COL_W`  column index of the captured pixel; 0 is the first shifted.
- `pix_top`  out  3  {R0,G0,B0} at capture.
- `pix_bot`  out  3  {R1,G1,B1} at capture.
- `line_valid`  out  1  one-cycle pulse per LAT rising edge.
- `line_row`  out  4  {D,C,B,A} sampled at the LAT edge.
- `line_cols`  out  `COL_W`+1  number of columns shifted since the previous latch.
- `err_len`  out  1  pulse with `line_valid` when `line_cols` ≠ `WIDTH`.
- `frame_start`  out  1  pulse with `line_valid` when `line_row` = 0.
- `frame_cnt`  out  8  count of `frame_start` pulses; wraps 255→0.
- `err_latch`  out  1  latch-while-lit error pulse; see Configuration.

## Operation

- Each bus input passes through a `SYNC_STAGES` flop chain.
- Edge detect compares the last synchroniser stage against one extra delayed copy. This applies to `clk_shft` and to `LAT`.
- RGB bits, row bits and `OE` are taken from the same synchronised stage as the edge detect, so they are cycle-aligned with it.
- States: IDLE (after reset, `col_cnt` = 0) and SHIFT (`col_cnt` > 0). The column counter `col_cnt` is `COL_W`+1 bits wide.
- On a `clk_shft` rise:
  - Emit a pixel event with `pix_col` = `col_cnt`[`COL_W`-1:0].
  - Increment `col_cnt`, saturating at `WIDTH`.
  - Columns beyond `WIDTH` still produce `pix_valid`, with `pix_col` held at `WIDTH`-1, and they force `err_len` at the next latch.
- On a `LAT` rise:
  - Drive `line_valid`, `line_row` and `line_cols`.
  - Assert `err_len` when the count ≠ `WIDTH` or overflow occurred.
  - Clear `col_cnt` and the overflow flag, and return to IDLE.
- Simultaneous `clk_shft` rise and `LAT` rise in the same cycle: the pixel is emitted and counted into the line being latched, then the counter clears.
- A `LAT` rise with zero columns is legal: `line_cols` = 0 and `err_len` = 1.
- `frame_start` fires whenever the latched row is 0, including repeated row-0 latches.
- Reset mid-line discards the partial line: no `line_valid` is issued for it.

## Timing

- Reset values: all outputs are 0; `frame_cnt` = 0; `col_cnt` = 0; synchroniser and edge flops are 0.
- A rising edge on `clk_shft` is detected while the input is low→high across 2 consecutive samples.
- Latency from an input edge to `pix_valid` or `line_valid` is `SYNC_STAGES`+1 `clk` cycles; this is 3 at the default.
- `pix_*` outputs and `line_row`/`line_cols` hold their values until the next event of their kind. Only the `*_valid`, `err_*` and `frame_start` signals are pulses.
- Input constraints:
  - `clk_shft` high and low times ≥ `SYNC_STAGES`+1 `clk` cycles.
  - RGB and row lines stable from 1 `clk` before to `SYNC_STAGES`+1 `clk` after the `clk_shft` or `LAT` rise.
- `frame_cnt` updates in the same cycle as `frame_start`.

## Configuration

- Macro `HUB75_RX_LATCH_GUARD_EN`.
- With the macro defined: `err_latch` pulses together with `line_valid` when the synchronised `OE` = 0 (display lit) at the `LAT` rise.
- Without the macro: `err_latch` is tied to 0 and no `OE` check logic is built. `OE` is still synchronised but otherwise unused.

## Test plan

- Reset, then shift 32 columns with alternating top = 3'b101 and bot = 3'b010, then LAT with row = 5 → 32 `pix_valid` pulses with `pix_col` 0..31; `line_valid` with `line_row` = 5, `line_cols` = 32, `err_len` = 0.
- Shift 31 columns, then LAT → `line_cols` = 31, `err_len` = 1. Shift 34 columns, then LAT → `line_cols` = 32, `err_len` = 1, last two `pix_col` = 31.
- `clk_shft` rise and `LAT` rise in the same cycle after 31 prior columns → final `pix_valid` with `pix_col` = 31; `line_cols` = 32, `err_len` = 0.
- Latch rows 15, 0, 1, …, 15, 0 → two `frame_start` pulses; `frame_cnt` = 2.
- Assert `rst` after 10 columns, then shift 32 and LAT → no line event for the partial line; the next line reports `line_cols` = 32; all outputs are 0 in the cycle after `rst`.
- With `HUB75_RX_LATCH_GUARD_EN` defined: LAT while `OE` = 0 → `err_latch` = 1; LAT while `OE` = 1 → 0. Without the macro: `err_latch` stays 0 in both cases.
